npu_result_reader: RTL and testbench

Read-side companion to the NPU's write-only SRAM-like buffer port. It captures the N signed PE accumulator results when the scheduler signals completion and holds them stable. It then serves them, plus a status word, over the same 32-bit word-addressed memory port through axi2mem. It lives beside the NPU top at its own base address and gives software result readback, overrun detection and an optional completion interrupt.

---
 rtl/npu_pkg.sv | 24 ++
 rtl/npu_result_reader_if.sv | 17 +
 rtl/npu_result_bank.sv | 53 +++++
 rtl/npu_result_reader.sv | 136 +++++++++++++
 tb/tb_npu_result_reader.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared constants for the NPU result reader: register map, STATUS/CTRL bit
// positions and the frame-holding state encoding.
package npu_pkg;

  localparam int ADDR_STATUS = 0;
  localparam int ADDR_CTRL   = 0;
  localparam int RESULT_BASE = 1;

  localparam int ST_READY     = 0;
  localparam int ST_OVERRUN   = 1;
  localparam int ST_IRQ_EN    = 2;
  localparam int ST_FRAME_LSB = 8;
  localparam int ST_MASK_LSB  = 16;

  localparam int CTRL_RELEASE = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_CLR_OVR = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/npu_result_reader_if.sv
// Word-addressed SRAM-like port (req/wen/addr/wdata in, registered rdata out).
// No wait states: every cycle may carry one access.
interface npu_result_reader_if #(
  parameter int ADDR_W    = 4,
  parameter int AXI_WIDTH = 32
) ();

  logic                 req_i;
  logic [3:0]           wen_i;
  logic [ADDR_W-1:0]    addr_i;
  logic [AXI_WIDTH-1:0] wdata_i;
  logic [AXI_WIDTH-1:0] rdata_o;

  modport master (output req_i, wen_i, addr_i, wdata_i, input rdata_o);
  modport slave  (input req_i, wen_i, addr_i, wdata_i, output rdata_o);

endinterface

// File: rtl/npu_result_bank.sv
// Capture registers for the N PE results plus the per-word read mask.
// Read data is combinational from the held registers; the mask clears on capture or clear.
module npu_result_bank #(
  parameter int N      = 10,
  parameter int W_ACC  = 24,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W_ACC-1:0] results_i,
  input  logic               capture,
  input  logic               mark_rd,
  input  logic [ADDR_W-1:0]  rd_idx,
  input  logic               mask_clr,
  output logic [W_ACC-1:0]   rd_data,
  output logic [N-1:0]       read_mask,
  output logic               rd_completes
);

  logic [W_ACC-1:0] res_q [N];
  logic [N-1:0]     rd_bit;

  always_comb begin
    rd_bit  = '0;
    rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_idx == ADDR_W'(i)) begin
        rd_bit[i] = 1'b1;
        rd_data   = res_q[i];
      end
    end
  end

  // True when this read would leave every word of the frame consumed.
  assign rd_completes = &(read_mask | rd_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) res_q[i] <= '0;
      read_mask <= '0;
    end else begin
      if (capture) begin
        for (int i = 0; i < N; i++) res_q[i] <= results_i[(i+1)*W_ACC-1 -: W_ACC];
      end
      if (capture || mask_clr) begin
        read_mask <= '0;
      end else if (mark_rd) begin
        read_mask <= read_mask | rd_bit;
      end
    end
  end

endmodule

// File: rtl/npu_result_reader.sv
// Holds one frame of PE results for software readback with STATUS/CTRL, overrun and irq.
// Reads return data one cycle later; accesses never stall, a new frame arriving while FULL is dropped.
module npu_result_reader
  import npu_pkg::*;
#(
  parameter int N         = 10,
  parameter int W_ACC     = 24,
  parameter int AXI_WIDTH = 32,
  parameter int ADDR_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N*W_ACC-1:0]  results_i,
  input  logic                res_valid_i,
  npu_result_reader_if.slave  bus,
  output logic                irq_o
);

  state_t st_q, st_d;
  logic       overrun_q;
  logic       irq_en_q;
  logic [7:0] frame_cnt_q;

  logic                 is_rd, is_wr, ctrl_wr, rd_res, rel_req, complete;
  logic                 addr_res;
  logic                 capture, overrun_set, mask_clr, mark_rd;
  logic [ADDR_W-1:0]    rd_idx;
  logic [W_ACC-1:0]     bank_rd;
  logic [N-1:0]         read_mask;
  logic                 rd_completes;
  logic [AXI_WIDTH-1:0] status, rd_word;

  wire unused_wdata = ^bus.wdata_i[AXI_WIDTH-1:3];

  assign is_wr    = bus.req_i & (|bus.wen_i);
  assign is_rd    = bus.req_i & ~(|bus.wen_i);
  assign addr_res = (bus.addr_i >= ADDR_W'(RESULT_BASE)) && (bus.addr_i <= ADDR_W'(N));
  assign rd_idx   = bus.addr_i - ADDR_W'(RESULT_BASE);
  assign ctrl_wr  = is_wr && (bus.addr_i == ADDR_W'(ADDR_CTRL));
  assign rd_res   = is_rd && addr_res;
  assign rel_req  = ctrl_wr && bus.wdata_i[CTRL_RELEASE];
  assign complete = rd_res && rd_completes;

  npu_result_bank #(
    .N      (N),
    .W_ACC  (W_ACC),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .results_i    (results_i),
    .capture      (capture),
    .mark_rd      (mark_rd),
    .rd_idx       (rd_idx),
    .mask_clr     (mask_clr),
    .rd_data      (bank_rd),
    .read_mask    (read_mask),
    .rd_completes (rd_completes)
  );

  // A frame that is released or fully read this cycle frees the slot for a
  // simultaneous res_valid_i, so that pulse is a capture rather than an overrun.
  always_comb begin
    st_d        = st_q;
    capture     = 1'b0;
    overrun_set = 1'b0;
    mask_clr    = rel_req;
    mark_rd     = 1'b0;
    case (st_q)
      EMPTY: begin
        if (res_valid_i) begin
          capture = 1'b1;
          st_d    = FULL;
        end
      end
      FULL: begin
        mark_rd = rd_res;
        if (rel_req || complete) begin
          mask_clr = 1'b1;
          st_d     = EMPTY;
        end
        if (res_valid_i) begin
          if (rel_req || complete) begin
            capture = 1'b1;
            st_d    = FULL;
          end else begin
            overrun_set = 1'b1;
          end
        end
      end
      default: st_d = EMPTY;
    endcase
  end

  always_comb begin
    status                          = '0;
    status[ST_READY]                = (st_q == FULL);
    status[ST_OVERRUN]              = overrun_q;
    status[ST_IRQ_EN]               = irq_en_q;
    status[ST_FRAME_LSB +: 8]       = frame_cnt_q;
    status[ST_MASK_LSB +: N]        = read_mask;
  end

  always_comb begin
    rd_word = '0;
    if (bus.addr_i == ADDR_W'(ADDR_STATUS)) begin
      rd_word = status;
    end else if (addr_res) begin
      rd_word = AXI_WIDTH'($signed(bank_rd));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= EMPTY;
      overrun_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      frame_cnt_q <= '0;
      bus.rdata_o <= '0;
      irq_o       <= 1'b0;
    end else begin
      st_q <= st_d;
      if (is_rd) bus.rdata_o <= rd_word;
      if (ctrl_wr) irq_en_q <= bus.wdata_i[CTRL_IRQ_EN];
      // Setting wins over a same-cycle clear request.
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (ctrl_wr && bus.wdata_i[CTRL_CLR_OVR]) begin
        overrun_q <= 1'b0;
      end
      if (capture) frame_cnt_q <= frame_cnt_q + 8'd1;
      irq_o <= (st_q == FULL) && irq_en_q;
    end
  end

endmodule

// File: tb/tb_npu_result_reader.sv
// Randomized bench for npu_result_reader with a frame-level reference model and read scoreboard.
module tb_npu_result_reader;

  localparam int N     = 10;
  localparam int W_ACC = 24;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N*W_ACC-1:0] results_i = '0;
  logic               res_valid_i = 1'b0;
  logic               irq_o;

  npu_result_reader_if #(.ADDR_W(4), .AXI_WIDTH(32)) ifc ();

  npu_result_reader #(
    .N         (N),
    .W_ACC     (W_ACC),
    .AXI_WIDTH (32),
    .ADDR_W    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .results_i   (results_i),
    .res_valid_i (res_valid_i),
    .bus         (ifc.slave),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one frame slot with a set of words already read.
  bit          m_full;
  bit          m_ovr;
  bit          m_irq_en;
  int          m_frame;
  bit          m_seen [N];
  logic [23:0] m_data [N];
  bit          exp_irq;

  logic [31:0] exp_q [$];
  bit          rd_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_ovr = 0; m_irq_en = 0; m_frame = 0; exp_irq = 0;
    for (int i = 0; i < N; i++) begin
      m_seen[i] = 0;
      m_data[i] = '0;
    end
  endtask

  function automatic logic [31:0] model_read(input int a);
    int s;
    int v;
    if (a == 0) begin
      s = (m_full ? 1 : 0) + (m_ovr ? 2 : 0) + (m_irq_en ? 4 : 0) + m_frame * 256;
      for (int i = 0; i < N; i++) if (m_seen[i]) s += (1 << (16 + i));
      return 32'(s);
    end
    if (a <= N) begin
      v = int'(m_data[a-1]);
      if (v >= (1 << 23)) v -= (1 << 24);
      return 32'(v);
    end
    return 32'h0;
  endfunction

  task automatic model_update(input bit rd, input bit wr, input int a, input logic [31:0] wd,
                              input bit rv, input logic [N*W_ACC-1:0] res);
    bit done;
    bit all;
    done = 0;
    if (rd && m_full && a >= 1 && a <= N) begin
      m_seen[a-1] = 1;
      all = 1;
      for (int i = 0; i < N; i++) if (!m_seen[i]) all = 0;
      done = all;
    end
    if (wr && a == 0) begin
      m_irq_en = wd[1];
      if (wd[2]) m_ovr = 0;
    end
    if (done || (wr && a == 0 && wd[0])) begin
      m_full = 0;
      for (int i = 0; i < N; i++) m_seen[i] = 0;
    end
    if (rv) begin
      if (!m_full) begin
        for (int i = 0; i < N; i++) begin
          m_data[i] = res[i*W_ACC +: W_ACC];
          m_seen[i] = 0;
        end
        m_frame = (m_frame + 1) % 256;
        m_full  = 1;
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  task automatic step(input bit req, input logic [3:0] wen, input int a, input logic [31:0] wd,
                      input bit rv, input logic [N*W_ACC-1:0] res);
    bit rd;
    bit wr;
    bit nxt_irq;
    ifc.req_i   = req;
    ifc.wen_i   = wen;
    ifc.addr_i  = a[3:0];
    ifc.wdata_i = wd;
    res_valid_i = rv;
    results_i   = res;
    rd = req && (wen == 4'h0);
    wr = req && (wen != 4'h0);
    if (rd) exp_q.push_back(model_read(a));
    nxt_irq = m_full && m_irq_en;
    @(posedge clk);
    model_update(rd, wr, a, wd, rv, res);
    exp_irq = nxt_irq;
    #1;
  endtask

  function automatic logic [N*W_ACC-1:0] rand_res();
    logic [N*W_ACC-1:0] r;
    for (int i = 0; i < N; i++) r[i*W_ACC +: W_ACC] = W_ACC'($urandom);
    return r;
  endfunction

  task automatic rd(input int a);
    step(1, 4'h0, a, 32'h0, 0, rand_res());
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    step(1, 4'hF, a, d, 0, rand_res());
  endtask

  task automatic idle();
    step(0, 4'h0, 0, 32'h0, 0, rand_res());
  endtask

  task automatic pulse(input logic [N*W_ACC-1:0] res);
    step(0, 4'h0, 0, 32'h0, 1, res);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    ifc.req_i = 0; ifc.wen_i = '0; ifc.addr_i = '0; ifc.wdata_i = '0;
    res_valid_i = 0;
    model_reset();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Read scoreboard: a read sampled on an edge is due on rdata_o before the next edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_seen <= 1'b0;
    else        rd_seen <= ifc.req_i && (ifc.wen_i == 4'h0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata: read response with empty scoreboard, got %08h", ifc.rdata_o);
        end else begin
          check("rdata", ifc.rdata_o, exp_q.pop_front());
        end
      end
      check("irq", {31'b0, irq_o}, {31'b0, exp_irq});
    end
  end

  logic [N*W_ACC-1:0] fr;

  initial begin
    model_reset();
    ifc.req_i = 0; ifc.wen_i = '0; ifc.addr_i = '0; ifc.wdata_i = '0;
    apply_reset();
    check("reset_rdata", ifc.rdata_o, 32'h0);
    check("reset_irq", {31'b0, irq_o}, 32'h0);
    rd(0);

    // First frame with irq enabled, known signed values in PE0/PE1.
    wr(0, 32'h2);
    fr = rand_res();
    fr[0 +: W_ACC]     = 24'h000005;
    fr[W_ACC +: W_ACC] = 24'hFFFFFE;
    pulse(fr);
    idle();
    rd(1); rd(2); rd(0);

    // Drain the whole frame back-to-back.
    for (int a = 1; a <= N; a++) rd(a);
    rd(0); idle(); idle();

    // Capture, then overrun while FULL; clear it through CTRL.
    pulse(rand_res());
    pulse(rand_res());
    rd(1); rd(0);
    wr(0, 32'h4);
    rd(0);

    // New frame arrives on the cycle the last word is read.
    for (int a = 1; a < N; a++) rd(a);
    step(1, 4'h0, N, 32'h0, 1, rand_res());
    rd(0); rd(1); rd(N); rd(N + 1); rd(15);

    // Writes to result and unmapped words are ignored.
    wr(3, 32'hDEAD_BEEF); wr(14, 32'h7); rd(3); rd(0);

    // 256 accepted captures wrap the frame counter.
    apply_reset();
    pulse(rand_res());
    for (int i = 0; i < 255; i++) step(1, 4'hF, 0, 32'h1, 1, rand_res());
    rd(0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int k;
      bit rv;
      logic [31:0] d;
      k  = $urandom_range(0, 99);
      rv = ($urandom_range(0, 9) == 0);
      d  = $urandom;
      if (k < 50) begin
        step(1, 4'h0, $urandom_range(0, 15), 32'h0, rv, rand_res());
      end else if (k < 65) begin
        if ($urandom_range(0, 7) != 0) d[0] = 1'b0;
        step(1, 4'($urandom_range(1, 15)), $urandom_range(0, 15), d, rv, rand_res());
      end else if (k < 68) begin
        for (int a = 1; a <= N; a++) rd(a);
      end else begin
        step(0, 4'h0, 0, 32'h0, rv, rand_res());
      end
    end

    // Asynchronous reset in the middle of a held frame.
    wr(0, 32'h3);
    fr = rand_res();
    fr[W_ACC +: W_ACC] = 24'hFFFFFE;
    pulse(fr);
    idle(); idle();
    rd(2);
    idle();
    rst_n = 0;
    #1;
    check("async_rst_rdata", ifc.rdata_o, 32'h0);
    check("async_rst_irq", {31'b0, irq_o}, 32'h0);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    rd(0); rd(2); idle(); idle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
